// File: rtl/bsg_aes_pkg.sv
// Shared widths, derived word counts and FSM state type for the AES word packer.
package bsg_aes_pkg;

    localparam int BSG_AES_KEY_W       = 256;
    localparam int BSG_AES_BLOCK_W     = 128;
    localparam int BSG_AES_WORD_W      = 32;
    localparam int BSG_AES_KEY_WORDS   = BSG_AES_KEY_W / BSG_AES_WORD_W;
    localparam int BSG_AES_BLOCK_WORDS = BSG_AES_BLOCK_W / BSG_AES_WORD_W;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } bsg_aes_state_e;

endpackage

// File: rtl/bsg_aes_word_shifter.sv
// Big-endian shift-in register: each enabled word enters at the LSBs, so the
// first word of a full load ends up in the most significant slot.
module bsg_aes_word_shifter
    import bsg_aes_pkg::*;
#(
    parameter int width_p      = BSG_AES_BLOCK_W,
    parameter int word_width_p = BSG_AES_WORD_W
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    input  logic [word_width_p-1:0] data_i,
    output logic [width_p-1:0]      data_o
);

    logic [width_p-1:0] data_d, data_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = {data_q[width_p-word_width_p-1:0], data_i};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_aes_word_packer.sv
// Packs a 32-bit key/plaintext word stream into a 384-bit {key, plaintext} word.
// Define BSG_AES_KEY_REUSE_EN to keep the key valid across consumed blocks.
module bsg_aes_word_packer
    import bsg_aes_pkg::*;
#(
    parameter int word_width_p  = BSG_AES_WORD_W,
    parameter int key_width_p   = BSG_AES_KEY_W,
    parameter int block_width_p = BSG_AES_BLOCK_W
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 v_i,
    input  logic [word_width_p-1:0]              data_i,
    input  logic                                 key_i,
    output logic                                 ready_o,
    output logic                                 v_o,
    output logic [key_width_p+block_width_p-1:0] data_o,
    input  logic                                 yumi_i,
    output logic                                 key_valid_o,
    output logic                                 error_o
);

    bsg_aes_state_e state_d, state_q;
    logic [2:0]     key_cnt_d, key_cnt_q;
    logic [1:0]     pt_cnt_d, pt_cnt_q;
    logic           key_valid_d, key_valid_q;
    logic           error_d, error_q;
    logic           accept;
    logic           key_shift_en, pt_shift_en;
    logic [key_width_p-1:0]   key_q;
    logic [block_width_p-1:0] pt_q;

    always_comb begin
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        pt_cnt_d     = pt_cnt_q;
        key_valid_d  = key_valid_q;
        error_d      = error_q;
        key_shift_en = 1'b0;
        pt_shift_en  = 1'b0;
        ready_o      = 1'b0;
        v_o          = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            COLLECT: begin
                ready_o = reset_n_i;
                accept  = v_i & ready_o;
                if (yumi_i) begin
                    error_d = 1'b1;
                end
                if (accept && key_i) begin
                    key_shift_en = 1'b1;
                    key_cnt_d    = key_cnt_q + 3'd1;
                    if (key_cnt_q == 3'd0) begin
                        key_valid_d = 1'b0;
                    end
                    if (key_cnt_q == 3'(BSG_AES_KEY_WORDS - 1)) begin
                        key_valid_d = 1'b1;
                    end
                end else if (accept) begin
                    // Plaintext without a complete key is swallowed; pt_cnt holds.
                    if (key_valid_q) begin
                        pt_shift_en = 1'b1;
                        pt_cnt_d    = pt_cnt_q + 2'd1;
                        if (pt_cnt_q == 2'(BSG_AES_BLOCK_WORDS - 1)) begin
                            state_d = FULL;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            FULL: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = COLLECT;
`ifdef BSG_AES_KEY_REUSE_EN
                    key_valid_d = key_valid_q;
`else
                    key_valid_d = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= COLLECT;
            key_cnt_q   <= '0;
            pt_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            pt_cnt_q    <= pt_cnt_d;
            key_valid_q <= key_valid_d;
            error_q     <= error_d;
        end
    end

    bsg_aes_word_shifter #(
        .width_p      (key_width_p),
        .word_width_p (word_width_p)
    ) key_shifter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (key_shift_en),
        .data_i    (data_i),
        .data_o    (key_q)
    );

    bsg_aes_word_shifter #(
        .width_p      (block_width_p),
        .word_width_p (word_width_p)
    ) pt_shifter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (pt_shift_en),
        .data_i    (data_i),
        .data_o    (pt_q)
    );

    // Both shifters are frozen while FULL, so data_o is stable until yumi_i.
    assign data_o      = {key_q, pt_q};
    assign key_valid_o = key_valid_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_bsg_aes_word_packer.sv
// Scoreboard bench for bsg_aes_word_packer; honours BSG_AES_KEY_REUSE_EN.
module tb_bsg_aes_word_packer;

`ifdef BSG_AES_KEY_REUSE_EN
    localparam bit reuse_c = 1'b1;
`else
    localparam bit reuse_c = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         v_i;
    logic [31:0]  data_i;
    logic         key_i;
    logic         ready_o;
    logic         v_o;
    logic [383:0] data_o;
    logic         yumi_i;
    logic         key_valid_o;
    logic         error_o;

    bsg_aes_word_packer dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .key_i       (key_i),
        .ready_o     (ready_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .key_valid_o (key_valid_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: key words indexed by arrival order, plaintext as a queue.
    logic [31:0]  m_key [8];
    int           m_kidx;
    bit           m_key_ok;
    bit           m_err;
    bit           m_full;
    logic [31:0]  m_pt [$];
    logic [383:0] sb [$];
    int           vo_cycles;

    logic [383:0] hold;
    bit           seen;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kidx   = 0;
        m_key_ok = 1'b0;
        m_err    = 1'b0;
        m_full   = 1'b0;
        m_pt.delete();
        sb.delete();
        for (int i = 0; i < 8; i++) m_key[i] = '0;
    endtask

    task automatic model_accept(input bit k, input logic [31:0] d);
        logic [383:0] exp;
        if (k) begin
            if (m_kidx == 0) m_key_ok = 1'b0;
            m_key[m_kidx] = d;
            m_kidx++;
            if (m_kidx == 8) begin
                m_kidx   = 0;
                m_key_ok = 1'b1;
            end
        end else if (!m_key_ok) begin
            m_err = 1'b1;
        end else begin
            m_pt.push_back(d);
            if (m_pt.size() == 4) begin
                exp = '0;
                for (int i = 0; i < 8; i++) exp[383 - 32*i -: 32] = m_key[i];
                for (int i = 0; i < 4; i++) exp[127 - 32*i -: 32] = m_pt[i];
                sb.push_back(exp);
                m_pt.delete();
                m_full = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive inputs, check control outputs at negedge, update model after the edge.
    task automatic step(input bit v, input bit k, input logic [31:0] d, input bit y);
        bit full_pre;
        v_i    = v;
        key_i  = k;
        data_i = d;
        yumi_i = y;
        @(negedge clk_i);
        check("ready_o", ready_o, !m_full);
        check("v_o", v_o, m_full);
        check("key_valid_o", key_valid_o, m_key_ok);
        check("error_o", error_o, m_err);
        if (v_o === 1'b1) vo_cycles++;
        @(posedge clk_i);
        #1;
        full_pre = m_full;
        if (v && !full_pre) model_accept(k, d);
        if (y) begin
            if (full_pre) begin
                m_full = 1'b0;
                if (!reuse_c) m_key_ok = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        v_i    = 1'b0;
        key_i  = 1'b0;
        yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        v_i       = 1'b0;
        key_i     = 1'b0;
        yumi_i    = 1'b0;
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_reset();
        @(negedge clk_i);
        check("rst_ready_o", ready_o, 0);
        check("rst_v_o", v_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_key_valid_o", key_valid_o, 0);
        check("rst_error_o", error_o, 0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    task automatic send_key(input logic [31:0] w0, input bit inc);
        for (int i = 0; i < 8; i++) begin
            if (inc) step(1'b1, 1'b1, w0 + 32'h04040404 * i, 1'b0);
            else     step(1'b1, 1'b1, w0, 1'b0);
        end
    endtask

    task automatic send_random_key();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, $urandom, 1'b0);
    endtask

    // Monitor: pops the scoreboard on the first cycle of each output, then checks stability.
    always @(negedge clk_i) begin
        if (reset_n_i !== 1'b1) begin
            seen = 1'b0;
        end else if (v_o === 1'b1) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", data_o, $time);
                end else begin
                    check("data_o", data_o, sb.pop_front());
                end
                hold = data_o;
                seen = 1'b1;
            end else begin
                check("data_o_stable", data_o, hold);
            end
            if (yumi_i === 1'b1) seen = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit v, k, y;
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        key_i     = 1'b0;
        data_i    = '0;
        yumi_i    = 1'b0;
        seen      = 1'b0;
        vo_cycles = 0;
        do_reset();

        // Basic block, then a 3-cycle stall and a second block reusing the key.
        send_key(32'h00010203, 1'b1);
        step(1'b1, 1'b0, 32'h00112233, 1'b0);
        step(1'b1, 1'b0, 32'h44556677, 1'b0);
        step(1'b1, 1'b0, 32'h8899aabb, 1'b0);
        step(1'b1, 1'b0, 32'hccddeeff, 1'b0);
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 32'hffffffff, 1'b0);
        step(1'b0, 1'b0, '0, m_full);
        step(1'b0, 1'b0, '0, 1'b0);

        // Plaintext with no key, then a normal block.
        do_reset();
        repeat (2) step(1'b1, 1'b0, $urandom, 1'b0);
        send_random_key();
        repeat (4) step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b0, 1'b0, '0, m_full);

        // Key reload in the middle of a plaintext block.
        do_reset();
        send_random_key();
        step(1'b1, 1'b0, 32'hdeadbeef, 1'b0);
        step(1'b1, 1'b0, 32'hcafef00d, 1'b0);
        send_key(32'ha5a5a5a5, 1'b0);
        step(1'b1, 1'b0, 32'h01234567, 1'b0);
        step(1'b1, 1'b0, 32'h89abcdef, 1'b0);
        step(1'b0, 1'b0, '0, m_full);

        // Reset after 5 key words, then a clean key and block.
        repeat (5) step(1'b1, 1'b1, $urandom, 1'b0);
        do_reset();
        send_random_key();
        repeat (4) step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b0, 1'b0, '0, m_full);

        // Throughput: continuous plaintext with yumi following the expected v_o.
        send_random_key();
        vo_cycles = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, $urandom, m_full);
        check("pulse_count", vo_cycles, reuse_c ? 4 : 1);

        // Randomized traffic including illegal yumi and interleaved key loads.
        do_reset();
        send_random_key();
        for (int i = 0; i < 300; i++) begin
            v = ($urandom % 4) != 0;
            k = ($urandom % 5) == 0;
            y = m_full ? (($urandom % 2) == 1) : (($urandom % 32) == 0);
            step(v, k, $urandom, y);
        end
        step(1'b0, 1'b0, '0, m_full);
        step(1'b0, 1'b0, '0, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_aes_word_packer.md
# bsg_aes_word_packer

Upstream feeder for `bsg_aes_encrypt`. It accepts a narrow 32-bit word stream carrying AES-256 key words and plaintext words, and assembles them into the 384-bit `{key, plaintext}` word the encryptor takes on `data_i`. It presents that word over a valid/yumi handshake. The key is held in a key register so that successive plaintext blocks can reuse it.

## Interface
- `word_width_p`, 32: input word width; fixed at 32.
- `key_width_p`, 256: AES key width.
- `block_width_p`, 128: AES block width.
- `clk_i`  in  1  clock; all logic on posedge.
- `reset_n_i`  in  1  synchronous, active-low reset.
- `v_i`  in  1  input word valid.
- `data_i`  in  32  input word.
- `key_i`  in  1  1 = word is a key word; 0 = word is a plaintext word.
- `ready_o`  out  1  packer can accept a word this cycle. A transfer happens when `v_i & ready_o`.
- `v_o`  out  1  assembled word valid.
- `data_o`  out  384  `[383:128]` is the key; `[127:0]` is the plaintext.
- `yumi_i`  in  1  consumer takes `data_o`; only legal when `v_o=1`.
- `key_valid_o`  out  1  a complete key is loaded.
- `error_o`  out  1  sticky protocol error.

## Operation
- FSM states:
  - COLLECT: `ready_o=1`.
  - FULL: `ready_o=0`, `v_o=1`.
- Key path:
  - 3-bit `key_cnt`. Words are big-endian: the first word lands in key bits `[255:224]`, the eighth in `[31:0]`.
  - Accepting a key word with `key_cnt=0` clears `key_valid_o` in the same edge.
  - Accepting the word with `key_cnt=7` sets `key_valid_o`; `key_cnt` wraps to 0.
- Plaintext path:
  - 2-bit `pt_cnt`, big-endian. The first word goes to `[127:96]`.
  - Plaintext words are written only while `key_valid_o=1`.
  - A plaintext word accepted while `key_valid_o=0` is consumed and dropped. It sets `error_o`, and `pt_cnt` is unchanged.
  - Accepting the word with `pt_cnt=3` moves COLLECT→FULL and wraps `pt_cnt` to 0.
- Key reload during a partial plaintext:
  - Key words are accepted and the partial plaintext is kept.
  - Further plaintext words are dropped with an error until the new key completes. Collection then resumes at the retained `pt_cnt`.
- FULL→COLLECT on `yumi_i`.
- `yumi_i` asserted while `v_o=0` sets `error_o` and is otherwise ignored.
- `data_o` is registered and stable for the whole time `v_o=1`.
- `error_o` is sticky and is cleared only by reset.

## Timing
- Reset (`reset_n_i=0` at posedge), all registers cleared:
  - `v_o=0`, `data_o=0`, `key_valid_o=0`, `error_o=0`, counters 0, state COLLECT.
  - `ready_o` is forced to 0 while `reset_n_i=0`.
- Reset mid-block discards all partial key and plaintext state.
- Latency: `v_o` rises the cycle after the fourth plaintext word is accepted.
- `ready_o` rises the cycle after `yumi_i`. There is no same-cycle bypass.
- Minimum block period with a loaded key is 5 cycles: 4 accepts plus 1 FULL cycle with immediate `yumi_i`.
- `ready_o` depends only on state and reset, never on `v_i`, `key_i` or `yumi_i`.
- In FULL, `v_i` is ignored and no words are accepted.

## Configuration
- `BSG_AES_KEY_REUSE_EN` defined:
  - The key persists across blocks.
  - `key_valid_o` stays 1 after `yumi_i` until the next key load begins.
- Not defined:
  - `key_valid_o` clears on every `yumi_i`, so each block needs a fresh 8-word key first.
  - A plaintext word arriving before that key completes is dropped and sets `error_o`.

## Structure
- Package `bsg_aes_pkg` holds:
  - Width constants: `BSG_AES_KEY_W=256`, `BSG_AES_BLOCK_W=128`, `BSG_AES_WORD_W=32`.
  - Derived word counts: 8 and 4.
  - The state enum `{COLLECT, FULL}`.
- Sub-module `bsg_aes_word_shifter` is a parameterized shift-in register with width and enable. It is instantiated twice: key (256) and plaintext (128).
- The top level holds the FSM, counters and error logic.

## Test plan
- Basic block, reuse on:
  - Stimulus: after reset, send key `00010203…1e1f` as 8 words, then plaintext `00112233_44556677_8899aabb_ccddeeff`.
  - Expected: `v_o=1` the next cycle with `data_o={000102…1f, 00112233…eeff}`. `key_valid_o=1`, `ready_o=0`.
- Key reuse with stalled consumer:
  - Stimulus: hold `yumi_i=0` for 3 cycles, then pulse it. Then send plaintext `ffffffff×4`.
  - Expected: `data_o` is stable during the stall. Second output is `{same key, ffff…ff}`. With the macro undefined, instead `error_o=1` and no second output.
- Plaintext with no key:
  - Stimulus: after reset, send 2 plaintext words.
  - Expected: `error_o=1`, `v_o` stays 0. A following key plus 4 plaintext words gives a normal output.
- Key reload mid-block:
  - Stimulus: after 2 plaintext words, send 8 key words of `a5a5a5a5`, then 2 more plaintext words `01234567`, `89abcdef`.
  - Expected: output key is `a5…a5`, and the plaintext keeps its first 2 words with `01234567_89abcdef` in the low 64 bits.
- Reset mid-key:
  - Stimulus: drop `reset_n_i` after 5 key words.
  - Expected: all outputs are 0 during and after reset. `key_cnt` restarts, so a new 8-word key loads correctly.
- Throughput:
  - Stimulus: continuous `v_i` plaintext with `yumi_i` tied to `v_o`.
  - Expected: one `v_o` pulse every 5 cycles, and `ready_o` low exactly on the FULL cycle.
